// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer pair: receiver states and
// the minimum frame length below which a frame is rejected.
package serial_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_t;

  localparam int MIN_FRAME_BITS = 3;

endpackage

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus between a bit source (master) and the deserializer (slave).
interface deserializer_if #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
);

  logic                      ser_data_i;
  logic                      ser_data_val_i;
  logic [DATA_BUS_WIDTH-1:0] deser_data_o;
  logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o;
  logic                      deser_data_val_o;
  logic                      deser_err_o;

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o,
    input  deser_err_o
  );

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o,
    output deser_err_o
  );

endinterface

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial frames into left-aligned parallel words with a bit count;
// frames of 1 or 2 bits are dropped and flagged with an error pulse.
module deserializer
  import serial_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BUS_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BUS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BUS_WIDTH - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME_BITS);
  localparam logic [DATA_BUS_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_BUS_WIDTH-1){1'b0}}};

  state_t                    state, state_next;
  logic [DATA_BUS_WIDTH-1:0] shift, shift_next;
  logic [CNT_W-1:0]          count, count_next;
  logic [DATA_BUS_WIDTH-1:0] slot;
  logic [DATA_BUS_WIDTH-1:0] data_next;
  logic [DATA_MOD_WIDTH-1:0] mod_next;
  logic                      val_next;
  logic                      err_next;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE_S;
    end else begin
      state <= state_next;
    end
  end

  // count == FULL_CNT in RECV_S marks the cycle right after a full word was emitted
  always_comb begin
    state_next = state;
    shift_next = shift;
    count_next = count;
    data_next  = bus.deser_data_o;
    mod_next   = bus.deser_data_mod_o;
    val_next   = 1'b0;
    err_next   = 1'b0;
    slot       = bus.ser_data_i ? (MSB_MASK >> count) : '0;
    case (state)
      IDLE_S: begin
        if (bus.ser_data_val_i) begin
          state_next = RECV_S;
          shift_next = bus.ser_data_i ? MSB_MASK : '0;
          count_next = CNT_W'(1);
        end
      end
      RECV_S: begin
        if (bus.ser_data_val_i) begin
          if (count == FULL_CNT) begin
            shift_next = bus.ser_data_i ? MSB_MASK : '0;
            count_next = CNT_W'(1);
          end else begin
            shift_next = shift | slot;
            count_next = count + CNT_W'(1);
            if (count == LAST_CNT) begin
              val_next  = 1'b1;
              data_next = shift_next;
              mod_next  = count_next[DATA_MOD_WIDTH-1:0];
            end
          end
        end else begin
          state_next = IDLE_S;
          count_next = '0;
          if (count != FULL_CNT) begin
            if (count >= MIN_CNT) begin
              val_next  = 1'b1;
              data_next = shift;
              mod_next  = count[DATA_MOD_WIDTH-1:0];
            end else begin
              err_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = state_t'('x);
        shift_next = 'x;
        count_next = 'x;
        data_next  = 'x;
        mod_next   = 'x;
        val_next   = 1'bx;
        err_next   = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift <= '0;
      count <= '0;
    end else begin
      shift <= shift_next;
      count <= count_next;
    end
  end

  // Data and mod hold their last emitted value; only the pulses return to 0
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.deser_data_o     <= '0;
      bus.deser_data_mod_o <= '0;
      bus.deser_data_val_o <= 1'b0;
      bus.deser_err_o      <= 1'b0;
    end else begin
      bus.deser_data_o     <= data_next;
      bus.deser_data_mod_o <= mod_next;
      bus.deser_data_val_o <= val_next;
      bus.deser_err_o      <= err_next;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: a frame-level bit-queue model checked every
// cycle, plus literal expectations for each scenario.
module tb_deserializer;

  localparam int W        = 16;
  localparam int M        = 4;
  localparam int MIN_BITS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  deserializer_if #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) bus ();

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  logic         frame_q[$];
  logic [W-1:0] exp_data;
  logic [M-1:0] exp_mod;
  logic         exp_val;
  logic         exp_err;

  logic [W-1:0] got_data[$];
  logic [M-1:0] got_mod[$];
  int           got_cyc[$];
  int           err_cnt;
  int           last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_frame();
    logic [W-1:0] w;
    w = '0;
    foreach (frame_q[i]) w[W-1-i] = frame_q[i];
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: a frame is the run of valid bits, closed at W bits or when valid drops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      exp_data = '0;
      exp_mod  = '0;
      exp_val  = 1'b0;
      exp_err  = 1'b0;
    end else begin
      exp_val = 1'b0;
      exp_err = 1'b0;
      if (bus.ser_data_val_i) begin
        if (frame_q.size() == W) frame_q.delete();
        frame_q.push_back(bus.ser_data_i);
        if (frame_q.size() == W) begin
          exp_val  = 1'b1;
          exp_data = pack_frame();
          exp_mod  = '0;
        end
      end else begin
        if (frame_q.size() >= MIN_BITS && frame_q.size() < W) begin
          exp_val  = 1'b1;
          exp_data = pack_frame();
          exp_mod  = M'(frame_q.size());
        end else if (frame_q.size() > 0 && frame_q.size() < MIN_BITS) begin
          exp_err = 1'b1;
        end
        frame_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_val", 32'(bus.deser_data_val_o), 32'(exp_val));
      chk("err",      32'(bus.deser_err_o),      32'(exp_err));
      chk("data",     32'(bus.deser_data_o),     32'(exp_data));
      chk("mod",      32'(bus.deser_data_mod_o), 32'(exp_mod));
      if (bus.deser_data_val_o === 1'b1) begin
        got_data.push_back(bus.deser_data_o);
        got_mod.push_back(bus.deser_data_mod_o);
        got_cyc.push_back(cyc);
      end
      if (bus.deser_err_o === 1'b1) err_cnt++;
    end
  end

  task automatic step(input logic v, input logic b);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w[W-1-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_mod.delete();
    got_cyc.delete();
    err_cnt = 0;
  endtask

  initial begin
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    err_cnt            = 0;
    last               = 0;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_data", 32'(bus.deser_data_o), 32'h0);
    chk("rst_mod",  32'(bus.deser_data_mod_o), 32'h0);
    chk("rst_val",  32'(bus.deser_data_val_o), 32'h0);
    chk("rst_err",  32'(bus.deser_err_o), 32'h0);
    idle(2);

    // 1: full 16-bit word
    clear_log();
    send_word(16'hA5C3, 16);
    last = cyc;
    idle(3);
    chk("t1_pulses", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) begin
      chk("t1_data", 32'(got_data[0]), 32'hA5C3);
      chk("t1_mod",  32'(got_mod[0]), 32'd0);
      chk("t1_lat",  32'(got_cyc[0] - (last - 1)), 32'd1);
    end
    chk("t1_err", 32'(err_cnt), 32'd0);

    // 2: 5-bit partial frame
    clear_log();
    send_word(16'hB000, 5);
    last = cyc;
    idle(3);
    chk("t2_pulses", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) begin
      chk("t2_data", 32'(got_data[0]), 32'hB000);
      chk("t2_mod",  32'(got_mod[0]), 32'd5);
      chk("t2_lat",  32'(got_cyc[0] - (last - 1)), 32'd2);
    end

    // 3: 2-bit frame dropped, outputs hold previous word
    clear_log();
    send_word(16'hC000, 2);
    idle(3);
    chk("t3_pulses", 32'(got_data.size()), 32'd0);
    chk("t3_err",    32'(err_cnt), 32'd1);
    chk("t3_hold_data", 32'(bus.deser_data_o), 32'hB000);
    chk("t3_hold_mod",  32'(bus.deser_data_mod_o), 32'd5);

    // 4: 20 contiguous ones
    clear_log();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    idle(3);
    chk("t4_pulses", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      chk("t4_data0", 32'(got_data[0]), 32'hFFFF);
      chk("t4_mod0",  32'(got_mod[0]), 32'd0);
      chk("t4_data1", 32'(got_data[1]), 32'hF000);
      chk("t4_mod1",  32'(got_mod[1]), 32'd4);
    end
    chk("t4_err", 32'(err_cnt), 32'd0);

    // 5: reset in the middle of a frame
    clear_log();
    send_word(16'hFE00, 7);
    bus.ser_data_val_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", 32'(bus.deser_data_o), 32'h0);
    chk("t5_rst_mod",  32'(bus.deser_data_mod_o), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(16'h1234, 16);
    idle(3);
    chk("t5_pulses", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) begin
      chk("t5_data", 32'(got_data[0]), 32'h1234);
      chk("t5_mod",  32'(got_mod[0]), 32'd0);
    end
    chk("t5_err", 32'(err_cnt), 32'd0);

    // 6: full word, one idle cycle, 3-bit frame
    clear_log();
    send_word(16'hFFFF, 16);
    idle(1);
    send_word(16'hA000, 3);
    idle(3);
    chk("t6_pulses", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      chk("t6_data0", 32'(got_data[0]), 32'hFFFF);
      chk("t6_mod0",  32'(got_mod[0]), 32'd0);
      chk("t6_data1", 32'(got_data[1]), 32'hA000);
      chk("t6_mod1",  32'(got_mod[1]), 32'd3);
    end

    // 7: one-cycle valid glitch, then a 3-bit frame of zeros after stale ones
    clear_log();
    step(1'b1, 1'b1);
    idle(3);
    send_word(16'h0000, 3);
    idle(3);
    chk("t7_err", 32'(err_cnt), 32'd1);
    chk("t7_pulses", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) begin
      chk("t7_data", 32'(got_data[0]), 32'h0000);
      chk("t7_mod",  32'(got_mod[0]), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
